// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: FSM state codes, command opcodes and command field layout.
// Also used by the debug data sender and the UART command path.
package debug_pkg;

  localparam int unsigned DBG_CMD_W   = 8;
  localparam int unsigned DBG_OP_W    = 2;
  localparam int unsigned DBG_OP_LSB  = DBG_CMD_W - DBG_OP_W;
  localparam int unsigned DBG_CNT_LSB = 0;
  localparam int unsigned DBG_CNT_W   = DBG_CMD_W - DBG_OP_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_CMD  = 3'd1,
    ST_STEP      = 3'd2,
    ST_RUN       = 3'd3,
    ST_SEND      = 3'd4,
    ST_WAIT_SEND = 3'd5,
    ST_DONE      = 3'd6
  } dbg_state_e;

  typedef enum logic [DBG_OP_W-1:0] {
    OP_STEP  = 2'b00,
    OP_RUN   = 2'b01,
    OP_ABORT = 2'b10,
    OP_RSVD  = 2'b11
  } dbg_op_e;

endpackage

// File: rtl/debug_step_ctrl_if.sv
// Signal bundle between debug_step_ctrl and the UART / pipeline / snapshot-sender side.
// With STEP_BREAKPOINT_EN defined the PC breakpoint inputs are added.
interface debug_step_ctrl_if #(
  parameter int unsigned CMD_W      = 8,
  parameter int unsigned STEP_CNT_W = 16,
  parameter int unsigned PC_W       = 32
) ();

  logic                  is_start;
  logic [CMD_W-1:0]      i_rx_data;
  logic                  is_rx_done;
  logic                  is_stop_pipe;
  logic                  is_done_send;
  logic                  os_step;
  logic                  os_start_send;
  logic                  os_done;
  logic                  os_cmd_err;
  logic                  os_send_tout;
  logic [STEP_CNT_W-1:0] o_step_cnt;
`ifdef STEP_BREAKPOINT_EN
  logic [PC_W-1:0]       i_pc;
  logic [PC_W-1:0]       i_bp_addr;
  logic                  is_bp_en;
`else
  localparam int unsigned unused_pc_w = PC_W;
`endif

  modport slave (
`ifdef STEP_BREAKPOINT_EN
    input  i_pc, i_bp_addr, is_bp_en,
`endif
    input  is_start, i_rx_data, is_rx_done, is_stop_pipe, is_done_send,
    output os_step, os_start_send, os_done, os_cmd_err, os_send_tout, o_step_cnt
  );

  modport master (
`ifdef STEP_BREAKPOINT_EN
    output i_pc, i_bp_addr, is_bp_en,
`endif
    output is_start, i_rx_data, is_rx_done, is_stop_pipe, is_done_send,
    input  os_step, os_start_send, os_done, os_cmd_err, os_send_tout, o_step_cnt
  );

endinterface

// File: rtl/dbg_timeout_cnt.sv
// Send-timeout counter: tc_o flags the TIMEOUT_CYC-th enabled cycle since the last clear.
// TIMEOUT_CYC = 0 builds no counter; tc_o is tied low.
module dbg_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, clr_i, en_i};
    assign tc_o      = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (en_i) begin
        cnt_d = tc_o ? '0 : cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug step controller: decodes UART commands, steps/runs the pipeline, then hands off to the
// snapshot sender. Optional PC breakpoint enabled by defining STEP_BREAKPOINT_EN.
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned CMD_W       = DBG_CMD_W,
  parameter int unsigned STEP_CNT_W  = 16,
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned PC_W        = 32
) (
  input logic              clk,
  input logic              rst,
  debug_step_ctrl_if.slave bus
);

  localparam int unsigned N_W         = CMD_W - DBG_OP_W;
  localparam int unsigned unused_pc_w = PC_W;

  dbg_state_e            state_q, state_d;
  logic [N_W-1:0]        remain_q, remain_d;
  logic                  halted_q, halted_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic                  step_q, step_d;
  logic                  send_q, send_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  tout_q, tout_d;
  logic                  tmo_clr, tmo_en, tmo_tc;
  logic                  bp_hit;
  dbg_op_e               op;
  logic [N_W-1:0]        n_cmd;

  assign op    = dbg_op_e'(bus.i_rx_data[CMD_W-1 -: DBG_OP_W]);
  assign n_cmd = bus.i_rx_data[N_W-1:0];

`ifdef STEP_BREAKPOINT_EN
  assign bp_hit = bus.is_bp_en && step_q && (bus.i_pc == bus.i_bp_addr);
`else
  assign bp_hit = 1'b0;
`endif

  dbg_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    send_d   = 1'b0;
    err_d    = 1'b0;
    tout_d   = 1'b0;
    tmo_clr  = 1'b0;
    tmo_en   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.is_start) begin
          state_d  = ST_WAIT_CMD;
          cnt_d    = '0;
          halted_d = 1'b0;
        end
      end
      ST_WAIT_CMD: begin
        if (bus.is_rx_done) begin
          unique case (op)
            OP_STEP: begin
              remain_d = (n_cmd == '0) ? N_W'(1) : n_cmd;
              state_d  = ST_STEP;
            end
            OP_RUN:   state_d = ST_RUN;
            OP_ABORT: state_d = ST_DONE;
            OP_RSVD:  err_d   = 1'b1;
          endcase
        end
      end
      // A stop or breakpoint refers to the step already visible on os_step, so the one being
      // decided this cycle is withheld.
      ST_STEP: begin
        if (bus.is_stop_pipe) begin
          halted_d = 1'b1;
          state_d  = ST_SEND;
        end else if (bp_hit) begin
          state_d = ST_SEND;
        end else begin
          step_d   = 1'b1;
          cnt_d    = cnt_q + STEP_CNT_W'(1);
          remain_d = remain_q - N_W'(1);
          if (remain_q == N_W'(1)) state_d = ST_SEND;
        end
      end
      ST_RUN: begin
        if (bus.is_stop_pipe) begin
          halted_d = 1'b1;
          state_d  = ST_SEND;
        end else if (bp_hit) begin
          state_d = ST_SEND;
        end else begin
          step_d = 1'b1;
          cnt_d  = cnt_q + STEP_CNT_W'(1);
        end
      end
      ST_SEND: begin
        send_d  = 1'b1;
        tmo_clr = 1'b1;
        state_d = ST_WAIT_SEND;
        // Halt reported alongside the final burst step is seen here.
        if (bus.is_stop_pipe && step_q) halted_d = 1'b1;
      end
      ST_WAIT_SEND: begin
        tmo_en = 1'b1;
        if (bus.is_done_send) begin
          state_d = halted_q ? ST_DONE : ST_WAIT_CMD;
        end else if (tmo_tc) begin
          tout_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      send_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      send_q   <= send_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
    end
  end

  assign bus.os_step       = step_q;
  assign bus.os_start_send = send_q;
  assign bus.os_done       = done_q;
  assign bus.os_cmd_err    = err_q;
  assign bus.os_send_tout  = tout_q;
  assign bus.o_step_cnt    = cnt_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Scoreboard bench for debug_step_ctrl: directed commands push expected output events,
// a negedge monitor turns DUT outputs into events and compares them in order.
module tb_debug_step_ctrl;
  import debug_pkg::*;

  localparam int unsigned CMD_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO   = 10;
  localparam int unsigned PC_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  debug_step_ctrl_if #(.CMD_W(CMD_W), .STEP_CNT_W(CNT_W), .PC_W(PC_W)) bus ();

  debug_step_ctrl #(
    .CMD_W(CMD_W), .STEP_CNT_W(CNT_W), .TIMEOUT_CYC(TMO), .PC_W(PC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef enum int {EV_STEP, EV_SEND, EV_TOUT, EV_ERR, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       a;
    int       b;
    int       c;
  } ev_t;

  ev_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  function automatic void push(input ev_kind_e k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endfunction

  task automatic report(input ev_kind_e k, input int a, input int b, input int c);
    ev_t e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s(%0d,%0d,%0d), required no event", k.name(), a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
        n_fail++;
        $display("FAIL event: got %s(%0d,%0d,%0d), required %s(%0d,%0d,%0d)",
                 k.name(), a, b, c, e.kind.name(), e.a, e.b, e.c);
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor. Event fields:
  //  STEP: a = cycles since is_rx_done at os_step rise
  //  SEND: a = steps since previous event, b = o_step_cnt, c = cycles since last step
  //  TOUT: a = cycles since os_start_send
  //  ERR/DONE: a = steps since previous event, b = o_step_cnt
  int   since_rx, since_send, run_len, gap;
  logic prev_step, prev_done;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      since_rx = 255; since_send = 255; run_len = 0; gap = 255;
      prev_step = 1'b0; prev_done = 1'b0;
    end else begin
      if (bus.is_rx_done) since_rx = 0;
      else if (since_rx < 255) since_rx++;
      if (bus.os_step) begin
        run_len++;
        gap = 0;
        if (!prev_step) report(EV_STEP, since_rx, 0, 0);
      end else if (gap < 255) begin
        gap++;
      end
      if (bus.os_start_send) begin
        report(EV_SEND, run_len, int'(bus.o_step_cnt), gap);
        run_len    = 0;
        since_send = 0;
      end else if (since_send < 255) begin
        since_send++;
      end
      if (bus.os_send_tout) report(EV_TOUT, since_send, 0, 0);
      if (bus.os_cmd_err) begin
        report(EV_ERR, run_len, int'(bus.o_step_cnt), 0);
        run_len = 0;
      end
      if (bus.os_done && !prev_done) begin
        report(EV_DONE, run_len, int'(bus.o_step_cnt), 0);
        run_len = 0;
      end
      prev_step = bus.os_step;
      prev_done = bus.os_done;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 bus.is_start = 1'b1;
    @(posedge clk); #1 bus.is_start = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1 bus.i_rx_data = b; bus.is_rx_done = 1'b1;
    @(posedge clk); #1 bus.is_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_send(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (bus.os_start_send) seen = 1'b1;
    end
    if (!seen) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s_send: got no os_start_send in 300 cycles, required one", nm);
    end
  endtask

  // Drive is_done_send d cycles after the observed os_start_send cycle.
  task automatic ack(input int d);
    repeat (d) @(posedge clk);
    #1 bus.is_done_send = 1'b1;
    @(posedge clk); #1 bus.is_done_send = 1'b0;
  endtask

  // Returns at the start of the cycle that shows the k-th consecutive step.
  task automatic wait_steps(input int k, input string nm);
    int seen;
    seen = 0;
    for (int c = 0; c < 300 && seen < k - 1; c++) begin
      @(negedge clk);
      if (bus.os_step) seen++;
    end
    if (seen < k - 1) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s_steps: got %0d steps, required %0d", nm, seen, k - 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic stop_on_step(input int k, input string nm);
    wait_steps(k, nm);
    bus.is_stop_pipe = 1'b1;
    @(posedge clk); #1 bus.is_stop_pipe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.is_start = 1'b0; bus.i_rx_data = '0; bus.is_rx_done = 1'b0;
    bus.is_stop_pipe = 1'b0; bus.is_done_send = 1'b0;
`ifdef STEP_BREAKPOINT_EN
    bus.i_pc = '0; bus.i_bp_addr = '0; bus.is_bp_en = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", 32'({bus.os_step, bus.os_start_send, bus.os_done, bus.os_cmd_err,
                           bus.os_send_tout}), 32'd0);
    check("rst_cnt", 32'(bus.o_step_cnt), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(posedge clk); #1 rst = 1'b1;

    // Reserved opcode, then abort, then a byte dropped in DONE
    push(EV_ERR, 0, 0, 0);
    pulse_start();
    send_rx(8'hC0);
    idle(3);
    push(EV_DONE, 0, 0, 0);
    send_rx(8'h80);
    send_rx(8'h03);
    idle(4);
    check("done_state", 32'(dut.state_q), 32'(ST_DONE));
    check("done_level", 32'(bus.os_done), 32'd1);

    // Burst of 3
    push(EV_STEP, 2, 0, 0); push(EV_SEND, 3, 3, 1);
    pulse_start();
    send_rx(8'h03);
    wait_send("burst3"); ack(1);
    idle(3);
    check("burst3_state", 32'(dut.state_q), 32'(ST_WAIT_CMD));

    // n=0 treated as 1; is_start ignored in WAIT_CMD
    push(EV_STEP, 2, 0, 0); push(EV_SEND, 1, 4, 1);
    pulse_start();
    send_rx(8'h00);
    wait_send("n0"); ack(2);
    idle(3);

    // Abort, then burst of 15 halted on the 5th step
    push(EV_DONE, 0, 4, 0);
    send_rx(8'h80);
    idle(3);
    push(EV_STEP, 2, 0, 0); push(EV_SEND, 5, 5, 2); push(EV_DONE, 0, 5, 0);
    pulse_start();
    send_rx(8'h0F);
    stop_on_step(5, "halt5");
    wait_send("halt5"); ack(1);
    idle(3);

    // RUN halted on the 20th step; 4-bit counter shows 20 mod 16
    push(EV_STEP, 2, 0, 0); push(EV_SEND, 20, 4, 2); push(EV_DONE, 0, 4, 0);
    pulse_start();
    send_rx(8'h40);
    stop_on_step(20, "run20");
    wait_send("run20"); ack(1);
    idle(3);

    // Halt coinciding with the last burst step: step counts, session ends
    push(EV_STEP, 2, 0, 0); push(EV_SEND, 3, 3, 1); push(EV_DONE, 0, 3, 0);
    pulse_start();
    send_rx(8'h03);
    stop_on_step(3, "lasthalt");
    wait_send("lasthalt"); ack(1);
    idle(3);

    // Send timeout and retransmit
    push(EV_STEP, 2, 0, 0); push(EV_SEND, 2, 2, 1); push(EV_TOUT, 10, 0, 0); push(EV_SEND, 0, 2, 12);
    pulse_start();
    send_rx(8'h02);
    wait_send("tout1");
    wait_send("tout2"); ack(1);
    idle(3);

    // done_send on the timeout cycle wins
    push(EV_STEP, 2, 0, 0); push(EV_SEND, 1, 3, 1);
    send_rx(8'h01);
    wait_send("tie"); ack(9);
    idle(15);
    check("tie_state", 32'(dut.state_q), 32'(ST_WAIT_CMD));

    // Counter wrap: 17 steps on a 4-bit counter
    push(EV_DONE, 0, 3, 0);
    send_rx(8'h80);
    idle(2);
    push(EV_STEP, 2, 0, 0); push(EV_SEND, 17, 1, 1);
    pulse_start();
    send_rx(8'h11);
    wait_send("wrap"); ack(1);
    idle(3);
    check("wrap_state", 32'(dut.state_q), 32'(ST_WAIT_CMD));

`ifdef STEP_BREAKPOINT_EN
    // Breakpoint on the 7th RUN step: send, back to WAIT_CMD, not halted
    push(EV_STEP, 2, 0, 0); push(EV_SEND, 7, 8, 2);
    bus.i_bp_addr = 32'h0000_0100; bus.i_pc = 32'h0; bus.is_bp_en = 1'b1;
    send_rx(8'h40);
    wait_steps(7, "bp7");
    bus.i_pc = 32'h0000_0100;
    @(posedge clk); #1 bus.i_pc = 32'h0;
    wait_send("bp7"); ack(1);
    idle(3);
    bus.is_bp_en = 1'b0;
    check("bp_state", 32'(dut.state_q), 32'(ST_WAIT_CMD));
    check("bp_done", 32'(bus.os_done), 32'd0);
`endif

    // Reset in the middle of RUN
    push(EV_STEP, 2, 0, 0);
    send_rx(8'h40);
    idle(6);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_outs", 32'({bus.os_step, bus.os_start_send, bus.os_done, bus.os_cmd_err,
                              bus.os_send_tout}), 32'd0);
    check("midrst_cnt", 32'(bus.o_step_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("midrst_step", 32'(bus.os_step), 32'd0);

    // Recovery after reset
    push(EV_STEP, 2, 0, 0); push(EV_SEND, 1, 1, 1);
    pulse_start();
    send_rx(8'h01);
    wait_send("recover"); ack(1);
    idle(5);

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_assert++;
      n_fail++;
      $display("FAIL missing_event: got nothing, required %s(%0d,%0d,%0d)", e.kind.name(), e.a, e.b, e.c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
